// File: rtl/mmm_pkg.sv
// Shared definitions for the matrix-multiply output path: frame geometry,
// counter sizing and the requantizer configuration record.
package mmm_pkg;

   localparam int M_ROWS         = 7;
   localparam int N_COLS         = 9;
   localparam int FRAME_LEN      = M_ROWS * N_COLS;
   localparam int CFG_SHIFT_BITS = 5;

   // Element counter width for a frame of len elements (never below one bit).
   function automatic int frame_cnt_w(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

   typedef struct packed {
      logic [CFG_SHIFT_BITS-1:0] shift;
      logic                      relu;
   } cfg_t;

endpackage

// File: rtl/requant_core.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic right
// shift on an INW+1-bit intermediate, then clamp to the signed OUTW range.
module requant_core #(
   parameter int INW        = 32,
   parameter int OUTW       = 12,
   parameter int SHIFT_BITS = 5
) (
   input  logic signed [INW-1:0]  x,
   input  logic [SHIFT_BITS-1:0]  shift,
   input  logic                   relu,
   output logic signed [OUTW-1:0] y,
   output logic                   sat
);

   localparam logic signed [INW:0] MAX_V = (INW+1)'((longint'(1) << (OUTW-1)) - 1);
   localparam logic signed [INW:0] MIN_V = ~MAX_V;

   logic signed [INW:0] wide;
   logic signed [INW:0] rnd;
   logic signed [INW:0] r;

   assign wide = {x[INW-1], x};

   always_comb begin
      rnd = '0;
      r   = wide;
      if (relu && x[INW-1]) begin
         r = '0;
      end else if (shift != '0) begin
         rnd = (INW+1)'(1) << (shift - 1'b1);
         r   = (wide + rnd) >>> shift;
      end
   end

   // A ReLU zero always lies inside the range, so it never flags sat.
   always_comb begin
      sat = 1'b0;
      y   = r[OUTW-1:0];
      if (r > MAX_V) begin
         y   = MAX_V[OUTW-1:0];
         sat = 1'b1;
      end else if (r < MIN_V) begin
         y   = MIN_V[OUTW-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/out_requant_framer.sv
// Output stage of the matrix-multiply core: two-register AXIS pipeline that
// requantizes each result element, tags the last element of every matrix with
// TLAST and keeps frame / saturation statistics.
module out_requant_framer
   import mmm_pkg::*;
#(
   parameter int INW        = 32,
   parameter int OUTW       = 12,
   parameter int M          = M_ROWS,
   parameter int N          = N_COLS,
   parameter int SHIFT_BITS = CFG_SHIFT_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SHIFT_BITS-1:0] cfg_shift,
   input  logic                  cfg_relu,
   input  logic                  cfg_valid,
   input  logic [INW-1:0]        S_AXIS_TDATA,
   input  logic                  S_AXIS_TVALID,
   output logic                  S_AXIS_TREADY,
   output logic [OUTW-1:0]       M_AXIS_TDATA,
   output logic                  M_AXIS_TVALID,
   output logic                  M_AXIS_TLAST,
   input  logic                  M_AXIS_TREADY,
   output logic [15:0]           frame_count,
   output logic [15:0]           sat_count
);

   localparam int            LEN      = M * N;
   localparam int            CW       = frame_cnt_w(LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

   cfg_t                   cfg_in;
   cfg_t                   shadow_reg;
   cfg_t                   active_reg;
   logic [CW-1:0]          elem_reg;

   logic                   a_valid_reg;
   logic                   a_last_reg;
   logic signed [INW-1:0]  a_data_reg;

   logic                   b_valid_reg;
   logic                   b_last_reg;
   logic signed [OUTW-1:0] b_data_reg;

   logic [15:0]            frame_reg;
   logic [15:0]            sat_reg;

   logic                   adv_a;
   logic                   adv_b;
   logic                   in_acc;
   logic                   out_acc;
   logic                   elem_is_last;
   logic signed [OUTW-1:0] rq_data;
   logic                   rq_sat;

   assign cfg_in       = {cfg_shift, cfg_relu};
   assign adv_b        = !b_valid_reg || M_AXIS_TREADY;
   assign adv_a        = !a_valid_reg || adv_b;
   assign in_acc       = S_AXIS_TVALID && adv_a;
   assign out_acc      = b_valid_reg && M_AXIS_TREADY;
   assign elem_is_last = (elem_reg == LAST_IDX);

   requant_core #(
      .INW        (INW),
      .OUTW       (OUTW),
      .SHIFT_BITS (SHIFT_BITS)
   ) u_requant (
      .x     (a_data_reg),
      .shift (active_reg.shift),
      .relu  (active_reg.relu),
      .y     (rq_data),
      .sat   (rq_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_reg  <= '0;
         active_reg  <= '0;
         elem_reg    <= '0;
         a_valid_reg <= 1'b0;
         a_last_reg  <= 1'b0;
         a_data_reg  <= '0;
         b_valid_reg <= 1'b0;
         b_last_reg  <= 1'b0;
         b_data_reg  <= '0;
         frame_reg   <= '0;
         sat_reg     <= '0;
      end else begin
         if (cfg_valid)
            shadow_reg <= cfg_in;

         // Active config only moves on element 0, where stage A is being
         // replaced, so the element it displaces was already computed with
         // the old setting.
         if (in_acc) begin
            elem_reg <= elem_is_last ? '0 : elem_reg + 1'b1;
            if (elem_reg == '0)
               active_reg <= cfg_valid ? cfg_in : shadow_reg;
         end

         if (adv_a) begin
            a_valid_reg <= S_AXIS_TVALID;
            if (S_AXIS_TVALID) begin
               a_data_reg <= S_AXIS_TDATA;
               a_last_reg <= elem_is_last;
            end
         end

         if (adv_b) begin
            b_valid_reg <= a_valid_reg;
            if (a_valid_reg) begin
               b_data_reg <= rq_data;
               b_last_reg <= a_last_reg;
               if (rq_sat && sat_reg != 16'hFFFF)
                  sat_reg <= sat_reg + 16'd1;
            end
         end

         if (out_acc && b_last_reg)
            frame_reg <= frame_reg + 16'd1;
      end
   end

   assign S_AXIS_TREADY = adv_a;
   assign M_AXIS_TDATA  = b_data_reg;
   assign M_AXIS_TVALID = b_valid_reg;
   assign M_AXIS_TLAST  = b_last_reg;
   assign frame_count   = frame_reg;
   assign sat_count     = sat_reg;

endmodule
